// File: rtl/serial_rcv_block.sv
// Serial receiver: start/data/stop frames on an idle-high line are reassembled
// into parallel words held in a one-word output buffer with status flags.
module serial_rcv_block #(
   parameter int unsigned NUM_DATA_BITS = 8,
   parameter int unsigned CLKS_PER_BIT  = 10,
   parameter bit          SHIFT_MSB     = 1'b0
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     serial_in,
   input  logic                     data_read,
   output logic [NUM_DATA_BITS-1:0] rx_data,
   output logic                     data_ready,
   output logic                     overrun_error,
   output logic                     framing_error
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(NUM_DATA_BITS + 2);
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_LOAD  = 3'd4;

   logic                     r_sync1;
   logic                     r_sync2;
   logic                     r_s_prev;
   logic [1:0]               r_fill;
   logic [2:0]               r_state;
   logic [CNT_W-1:0]         r_clk_cnt;
   logic [BIT_W-1:0]         r_bit_cnt;
   logic [NUM_DATA_BITS-1:0] r_shift;
   logic                     r_stop_bit;

   logic [2:0] w_next_state;
   logic       w_s;
   logic       w_start_edge;
   logic       w_half_tick;
   logic       w_full_tick;
   logic       w_cnt_clr;
   logic       w_commit;
   logic       w_frame_err;

   assign w_s = r_sync2;

   // Edge detection is held off until s and s_prev carry real line samples,
   // so a frame in flight at reset release waits for its next falling edge.
   assign w_start_edge = (r_state == ST_IDLE) && (r_fill == 2'd3) && r_s_prev && !w_s;
   assign w_half_tick  = (r_clk_cnt == CNT_W'(HALF - 1));
   assign w_full_tick  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_commit     = (r_state == ST_LOAD) && r_stop_bit;
   assign w_frame_err  = (r_state == ST_LOAD) && !r_stop_bit;

   // Input synchronizer, previous-value flop and post-reset fill counter
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_s_prev <= 1'b1;
         r_fill   <= 2'd0;
      end else begin
         r_sync1  <= serial_in;
         r_sync2  <= r_sync1;
         r_s_prev <= r_sync2;
         if (r_fill != 2'd3) begin
            r_fill <= r_fill + 2'd1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and bit-timer restart
   always_comb begin
      w_next_state = r_state;
      w_cnt_clr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_clr = 1'b1;
            if (w_start_edge) begin
               w_next_state = ST_START;
            end
         end
         ST_START: begin
            if (w_half_tick) begin
               w_cnt_clr    = 1'b1;
               w_next_state = w_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_full_tick) begin
               w_cnt_clr = 1'b1;
               if (r_bit_cnt == BIT_W'(NUM_DATA_BITS - 1)) begin
                  w_next_state = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (w_full_tick) begin
               w_cnt_clr    = 1'b1;
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_cnt_clr    = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_cnt_clr    = 1'b1;
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Bit timing, data bit count, shift register and stop-bit capture
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_clk_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_stop_bit <= 1'b0;
      end else begin
         r_clk_cnt <= w_cnt_clr ? '0 : r_clk_cnt + CNT_W'(1);
         if (r_state == ST_IDLE || r_state == ST_START) begin
            r_bit_cnt <= '0;
         end else if (r_state == ST_DATA && w_full_tick) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (SHIFT_MSB) begin
               r_shift <= {r_shift[NUM_DATA_BITS-2:0], w_s};
            end else begin
               r_shift <= {w_s, r_shift[NUM_DATA_BITS-1:1]};
            end
         end
         if (r_state == ST_STOP && w_full_tick) begin
            r_stop_bit <= w_s;
         end
      end
   end

   // Output buffer and status flags; a committing LOAD takes priority over data_read
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_data       <= '1;
         data_ready    <= 1'b0;
         overrun_error <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         if (w_commit) begin
            rx_data       <= r_shift;
            data_ready    <= 1'b1;
            overrun_error <= (data_ready && !data_read) || (overrun_error && !data_read);
         end else if (data_read && data_ready) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
         end
         if (w_commit) begin
            framing_error <= 1'b0;
         end else if (w_frame_err) begin
            framing_error <= 1'b1;
         end else if (w_start_edge) begin
            framing_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_rcv_block.sv
// Scoreboard bench for serial_rcv_block: one LSB-first and one MSB-first instance
// driven with serial frames, expected buffer/flag state predicted per frame.
module tb_serial_rcv_block;

   localparam int C = 10;

   typedef struct packed {
      logic [7:0] data;
      logic       rdy;
      logic       ovr;
      logic       fe;
   } exp_t;

   logic       clk;
   logic       n_rst;
   logic       ser [2];
   logic       rd  [2];
   logic [7:0] rx  [2];
   logic       rdy [2];
   logic       ovr [2];
   logic       fe  [2];

   logic [7:0] m_rx  [2];
   logic       m_rdy [2];
   logic       m_ovr [2];
   logic       m_fe  [2];

   exp_t sb[$];
   int   n_checks;
   int   n_fail;

   serial_rcv_block #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(C), .SHIFT_MSB(1'b0)) u_dut (
      .clk(clk), .n_rst(n_rst), .serial_in(ser[0]), .data_read(rd[0]),
      .rx_data(rx[0]), .data_ready(rdy[0]), .overrun_error(ovr[0]), .framing_error(fe[0])
   );

   serial_rcv_block #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(C), .SHIFT_MSB(1'b1)) u_dut_m (
      .clk(clk), .n_rst(n_rst), .serial_in(ser[1]), .data_read(rd[1]),
      .rx_data(rx[1]), .data_ready(rdy[1]), .overrun_error(ovr[1]), .framing_error(fe[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_rx[d]  = 8'hFF;
         m_rdy[d] = 1'b0;
         m_ovr[d] = 1'b0;
         m_fe[d]  = 1'b0;
      end
   endtask

   task automatic check_model(input string tag, input int d);
      check_val({tag, "_rx"},  32'(rx[d]),  32'(m_rx[d]));
      check_val({tag, "_rdy"}, 32'(rdy[d]), 32'(m_rdy[d]));
      check_val({tag, "_ovr"}, 32'(ovr[d]), 32'(m_ovr[d]));
      check_val({tag, "_fe"},  32'(fe[d]),  32'(m_fe[d]));
   endtask

   // Drives one full frame; the commit lands on the 99th edge after the start bit
   task automatic send_frame(input string tag, input int d, input logic [7:0] w,
                             input logic stop, input bit lat, input int brk);
      exp_t e;
      logic pre_rdy;
      pre_rdy = m_rdy[d];
      if (stop) begin
         if (m_rdy[d]) m_ovr[d] = 1'b1;
         m_rx[d]  = w;
         m_rdy[d] = 1'b1;
         m_fe[d]  = 1'b0;
      end else begin
         m_fe[d] = 1'b1;
      end
      e.data = m_rx[d];
      e.rdy  = m_rdy[d];
      e.ovr  = m_ovr[d];
      e.fe   = m_fe[d];
      sb.push_back(e);

      @(posedge clk); #1 ser[d] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (C) @(posedge clk);
         #1 ser[d] = (d == 1) ? w[7-i] : w[i];
      end
      repeat (C) @(posedge clk);
      #1 ser[d] = stop;
      repeat (8) @(posedge clk);
      #1;
      if (lat) check_val({tag, "_lat_pre"}, 32'(rdy[d]), 32'(pre_rdy));
      @(posedge clk); #1;
      if (lat) check_val({tag, "_lat_post"}, 32'(rdy[d]), 32'(e.rdy));
      @(posedge clk); #1;
      repeat (brk) @(posedge clk);
      #1 ser[d] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val({tag, "_rx"},  32'(rx[d]),  32'(e.data));
      check_val({tag, "_rdy"}, 32'(rdy[d]), 32'(e.rdy));
      check_val({tag, "_ovr"}, 32'(ovr[d]), 32'(e.ovr));
      check_val({tag, "_fe"},  32'(fe[d]),  32'(e.fe));
   endtask

   task automatic read_word(input string tag, input int d);
      @(posedge clk); #1 rd[d] = 1'b1;
      @(posedge clk); #1 rd[d] = 1'b0;
      if (m_rdy[d]) begin
         m_rdy[d] = 1'b0;
         m_ovr[d] = 1'b0;
      end
      check_val({tag, "_rdy"}, 32'(rdy[d]), 32'(m_rdy[d]));
      check_val({tag, "_ovr"}, 32'(ovr[d]), 32'(m_ovr[d]));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w;
      n_checks = 0;
      n_fail   = 0;
      ser[0] = 1'b1; ser[1] = 1'b1;
      rd[0]  = 1'b0; rd[1]  = 1'b0;
      n_rst  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_model("in_reset", 0);
      n_rst = 1'b1;

      // Idle line after reset
      repeat (50) @(posedge clk);
      #1 check_model("idle", 0);
      check_model("idle_m", 1);

      // Basic frame with latency check, then read
      send_frame("a5", 0, 8'hA5, 1'b1, 1'b1, 0);
      read_word("a5_read", 0);

      // Overrun
      send_frame("3c", 0, 8'h3C, 1'b1, 1'b0, 0);
      send_frame("c3", 0, 8'hC3, 1'b1, 1'b0, 0);
      read_word("ovr_read", 0);

      // Framing error with a held-low break, then recovery
      send_frame("55_fe", 0, 8'h55, 1'b0, 1'b0, 40);
      send_frame("0f", 0, 8'h0F, 1'b1, 1'b0, 0);
      read_word("0f_read", 0);

      // Short low pulse is a false start
      @(posedge clk); #1 ser[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 ser[0] = 1'b1;
      repeat (30) @(posedge clk);
      #1 check_model("false_start", 0);
      send_frame("81", 0, 8'h81, 1'b1, 1'b0, 0);

      // Reset during data bit 4 of a frame
      w = 8'h96;
      @(posedge clk); #1 ser[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         repeat (C) @(posedge clk);
         #1 ser[0] = w[i];
      end
      repeat (4) @(posedge clk);
      #3 n_rst = 1'b0;
      model_reset();
      #1 check_model("mid_rst", 0);
      ser[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (10) @(posedge clk);
      send_frame("e7", 0, 8'hE7, 1'b1, 1'b0, 0);

      // MSB-first instance
      send_frame("a5_msb", 1, 8'hA5, 1'b1, 1'b1, 0);
      read_word("a5_msb_read", 1);
      check_model("end_lsb", 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
